// File: rtl/switch_allocator.sv
// Wormhole switch allocator: XY routing, per-output round-robin grant and
// packet locking. Each output holds one input until the last flit of its packet.
module switch_allocator #(
    parameter int DATA_WIDTH              = 32,
    parameter int CHANNEL_NUMBER          = 5,
    parameter int MAX_ROUTERS_X           = 4,
    parameter int MAX_ROUTERS_Y           = 4,
    parameter int ROUTER_X                = 0,
    parameter int ROUTER_Y                = 0,
    parameter int MAXIMUM_PACKAGES_NUMBER = 5
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [CHANNEL_NUMBER-1:0]                       in_valid,
    input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0]            in_data,
    output logic [CHANNEL_NUMBER-1:0]                       in_ready,
    input  logic [CHANNEL_NUMBER-1:0]                       out_ready,
    output logic [CHANNEL_NUMBER-1:0]                       out_valid,
    output logic [CHANNEL_NUMBER*$clog2(CHANNEL_NUMBER)-1:0] out_sel,
    output logic [CHANNEL_NUMBER-1:0]                       out_busy
);

    localparam int SEL_W = $clog2(CHANNEL_NUMBER);
    localparam int X_W   = $clog2(MAX_ROUTERS_X);
    localparam int Y_W   = $clog2(MAX_ROUTERS_Y);
    localparam int CNT_W = $clog2(MAXIMUM_PACKAGES_NUMBER);
    localparam logic [CNT_W-1:0] N_MAX = CNT_W'(MAXIMUM_PACKAGES_NUMBER - 1);
    localparam logic [X_W-1:0]   MY_X  = X_W'(ROUTER_X);
    localparam logic [Y_W-1:0]   MY_Y  = Y_W'(ROUTER_Y);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state_r  [CHANNEL_NUMBER];
    logic [CNT_W-1:0]   cnt_r    [CHANNEL_NUMBER];
    logic [SEL_W-1:0]   sel_r    [CHANNEL_NUMBER];
    logic [SEL_W-1:0]   rr_r     [CHANNEL_NUMBER];
    logic               head_r   [CHANNEL_NUMBER];
    logic [CHANNEL_NUMBER-1:0] bound_r;

    logic [SEL_W-1:0]          route_s     [CHANNEL_NUMBER];
    logic [CHANNEL_NUMBER-1:0] req_s       [CHANNEL_NUMBER];
    logic                      grant_vld_s [CHANNEL_NUMBER];
    logic [SEL_W-1:0]          grant_idx_s [CHANNEL_NUMBER];
    logic                      xfer_s      [CHANNEL_NUMBER];
    logic                      release_s   [CHANNEL_NUMBER];
    logic [CNT_W-1:0]          hdr_n_s     [CHANNEL_NUMBER];
    logic                      unused_data_s;

    function automatic logic [SEL_W-1:0] xy_route(input logic [DATA_WIDTH-1:0] flit);
        logic [X_W-1:0] tx;
        logic [Y_W-1:0] ty;
        tx = flit[X_W-1:0];
        ty = flit[X_W+Y_W-1:X_W];
        if (tx > MY_X)      xy_route = SEL_W'(3);
        else if (tx < MY_X) xy_route = SEL_W'(4);
        else if (ty > MY_Y) xy_route = SEL_W'(2);
        else if (ty < MY_Y) xy_route = SEL_W'(1);
        else                xy_route = SEL_W'(0);
    endfunction

    // Oversized body counts are clamped to the largest packet the router supports.
    function automatic logic [CNT_W-1:0] hdr_count(input logic [DATA_WIDTH-1:0] flit);
        logic [CNT_W-1:0] n;
        n = flit[X_W+Y_W +: CNT_W];
        if (n > N_MAX) hdr_count = N_MAX;
        else           hdr_count = n;
    endfunction

    assign unused_data_s = ^in_data;

    // Route every input's current flit and raise its request when unbound
    always_comb begin
        for (int o = 0; o < CHANNEL_NUMBER; o++) begin
            req_s[o] = '0;
        end
        for (int i = 0; i < CHANNEL_NUMBER; i++) begin
            route_s[i] = xy_route(in_data[i*DATA_WIDTH +: DATA_WIDTH]);
            for (int o = 0; o < CHANNEL_NUMBER; o++) begin
                req_s[o][i] = in_valid[i] && !bound_r[i] && (route_s[i] == SEL_W'(o));
            end
        end
    end

    // Round-robin search per output starting one past the last winner
    always_comb begin
        for (int o = 0; o < CHANNEL_NUMBER; o++) begin
            grant_vld_s[o] = 1'b0;
            grant_idx_s[o] = '0;
            for (int k = 1; k <= CHANNEL_NUMBER; k++) begin
                if (!grant_vld_s[o] && req_s[o][(int'(rr_r[o]) + k) % CHANNEL_NUMBER]) begin
                    grant_vld_s[o] = 1'b1;
                    grant_idx_s[o] = SEL_W'((int'(rr_r[o]) + k) % CHANNEL_NUMBER);
                end else begin
                    grant_vld_s[o] = grant_vld_s[o];
                end
            end
        end
    end

    // Detect transfers and the final flit of each locked packet
    always_comb begin
        for (int o = 0; o < CHANNEL_NUMBER; o++) begin
            hdr_n_s[o] = hdr_count(in_data[int'(sel_r[o])*DATA_WIDTH +: DATA_WIDTH]);
            xfer_s[o]  = (state_r[o] == BUSY) && in_valid[sel_r[o]] && out_ready[o];
            if (head_r[o]) begin
                release_s[o] = xfer_s[o] && (hdr_n_s[o] == {CNT_W{1'b0}});
            end else begin
                release_s[o] = xfer_s[o] && (cnt_r[o] == CNT_W'(1));
            end
        end
    end

    // Handshake outputs; everything is forced quiet while reset is asserted
    always_comb begin
        in_ready  = '0;
        out_valid = '0;
        out_busy  = '0;
        out_sel   = '0;
        for (int o = 0; o < CHANNEL_NUMBER; o++) begin
            out_sel[o*SEL_W +: SEL_W] = sel_r[o];
            if (!rst && (state_r[o] == BUSY)) begin
                out_busy[o]  = 1'b1;
                out_valid[o] = in_valid[sel_r[o]];
                for (int i = 0; i < CHANNEL_NUMBER; i++) begin
                    if (sel_r[o] == SEL_W'(i)) in_ready[i] = in_ready[i] | out_ready[o];
                    else                       in_ready[i] = in_ready[i];
                end
            end else begin
                out_busy[o] = 1'b0;
            end
        end
    end

    // Per-output IDLE/BUSY state, flit counter, selection and input binding
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < CHANNEL_NUMBER; o++) begin
                state_r[o] <= IDLE;
                cnt_r[o]   <= '0;
                sel_r[o]   <= '0;
                rr_r[o]    <= SEL_W'(CHANNEL_NUMBER - 1);
                head_r[o]  <= 1'b0;
            end
            bound_r <= '0;
        end else begin
            for (int o = 0; o < CHANNEL_NUMBER; o++) begin
                case (state_r[o])
                    IDLE: begin
                        if (grant_vld_s[o]) begin
                            state_r[o]              <= BUSY;
                            sel_r[o]                <= grant_idx_s[o];
                            rr_r[o]                 <= grant_idx_s[o];
                            head_r[o]               <= 1'b1;
                            bound_r[grant_idx_s[o]] <= 1'b1;
                        end
                    end
                    BUSY: begin
                        if (release_s[o]) begin
                            state_r[o]        <= IDLE;
                            head_r[o]         <= 1'b0;
                            cnt_r[o]          <= '0;
                            bound_r[sel_r[o]] <= 1'b0;
                        end else if (xfer_s[o] && head_r[o]) begin
                            cnt_r[o]  <= hdr_n_s[o];
                            head_r[o] <= 1'b0;
                        end else if (xfer_s[o]) begin
                            cnt_r[o] <= cnt_r[o] - CNT_W'(1);
                        end
                    end
                    default: state_r[o] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator at router (1,1): sources stream queued
// packets, the monitor pops expected flits per output as transfers occur.
module tb_switch_allocator;

    localparam int DW = 32;
    localparam int CN = 5;
    localparam int SW = 3;

    logic              clk;
    logic              rst;
    logic [CN-1:0]     in_valid;
    logic [CN*DW-1:0]  in_data;
    logic [CN-1:0]     in_ready;
    logic [CN-1:0]     out_ready;
    logic [CN-1:0]     out_valid;
    logic [CN*SW-1:0]  out_sel;
    logic [CN-1:0]     out_busy;

    logic [DW-1:0] src_q [CN][$];
    logic [DW-1:0] exp_q [CN][$];
    logic [CN-1:0] acc;
    int n_checks = 0;
    int n_fail   = 0;
    int seq      = 0;

    switch_allocator #(
        .DATA_WIDTH(32), .CHANNEL_NUMBER(5), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4),
        .ROUTER_X(1), .ROUTER_Y(1), .MAXIMUM_PACKAGES_NUMBER(5)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
        .out_sel(out_sel), .out_busy(out_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference XY route for router (1,1)
    function automatic int tb_route(input logic [7:0] h);
        if (h[1:0] > 2'd1) return 3;
        if (h[1:0] < 2'd1) return 4;
        if (h[3:2] > 2'd1) return 2;
        if (h[3:2] < 2'd1) return 1;
        return 0;
    endfunction

    task automatic push_pkt(input int src, input logic [7:0] hdr);
        int dst;
        int n;
        logic [DW-1:0] f;
        dst = tb_route(hdr);
        n = (int'(hdr[6:4]) > 4) ? 4 : int'(hdr[6:4]);
        seq++;
        f = {seq[15:0], 8'h00, hdr};
        src_q[src].push_back(f);
        exp_q[dst].push_back(f);
        for (int k = 1; k <= n; k++) begin
            f = {seq[15:0], 8'(k), 8'hB0};
            src_q[src].push_back(f);
            exp_q[dst].push_back(f);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Source driver: retire accepted flits, present the next queued one
    initial begin
        in_valid = '0;
        in_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < CN; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    in_valid[i] = 1'b1;
                    in_data[i*DW +: DW] = src_q[i][0];
                end else begin
                    in_valid[i] = 1'b0;
                    in_data[i*DW +: DW] = '0;
                end
            end
        end
    end

    // Monitor: compare each output transfer against the scoreboard
    initial begin
        logic [DW-1:0] obs;
        logic [DW-1:0] exp_f;
        int s;
        acc = '0;
        forever begin
            @(negedge clk);
            acc = in_valid & in_ready;
            for (int o = 0; o < CN; o++) begin
                if (out_valid[o] && out_ready[o]) begin
                    s = int'(out_sel[o*SW +: SW]);
                    obs = in_data[s*DW +: DW];
                    n_checks++;
                    if (exp_q[o].size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected out%0d: got %h want none", o, obs);
                    end else begin
                        exp_f = exp_q[o].pop_front();
                        if (obs !== exp_f) begin
                            n_fail++;
                            $display("FAIL sb_data out%0d: got %h want %h", o, obs, exp_f);
                        end
                    end
                    n_checks++;
                    if (in_ready[s] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL sb_in_ready in%0d: got %b want 1", s, in_ready[s]);
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string nm);
        int cyc;
        bit done;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            done = (out_busy == '0);
            for (int i = 0; i < CN; i++) begin
                if (src_q[i].size() != 0 || exp_q[i].size() != 0) done = 1'b0;
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_drain: got busy=%b after %0d cycles want drained", nm, out_busy, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = '1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_busy, in_ready} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_during: got %b want 0", {out_valid, out_busy, in_ready});
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_busy, in_ready, out_sel} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_after: got %b want 0", {out_valid, out_busy, in_ready, out_sel});
        end
    endtask

    task automatic test_single();
        push_pkt(0, 8'h23);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_busy[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_req_cycle: got busy %b want 0", out_busy[3]);
        end
        @(negedge clk);
        n_checks++;
        if (out_busy[3] !== 1'b1 || out_sel[3*SW +: SW] !== 3'd0 || out_valid[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: got busy %b sel %0d valid %b want 1 0 1",
                     out_busy[3], out_sel[3*SW +: SW], out_valid[3]);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_busy[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_mid: got busy %b want 1", out_busy[3]);
        end
        @(negedge clk);
        n_checks++;
        if (out_busy[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: got busy %b want 0", out_busy[3]);
        end
        wait_idle("single");
    endtask

    task automatic test_contention();
        rst = 1'b1;
        step();
        rst = 1'b0;
        push_pkt(1, 8'h05);
        push_pkt(2, 8'h05);
        push_pkt(1, 8'h05);
        push_pkt(2, 8'h05);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_busy[0] !== 1'b1 || out_sel[0 +: SW] !== 3'd1) begin
            n_fail++;
            $display("FAIL contention_first: got busy %b sel %0d want 1 1", out_busy[0], out_sel[0 +: SW]);
        end
        wait_idle("contention");
    endtask

    task automatic test_backpressure();
        push_pkt(0, 8'h33);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        out_ready[3] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready[0] !== 1'b0 || out_valid[3] !== 1'b1 || out_busy[3] !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got rdy %b valid %b busy %b want 0 1 1",
                         c, in_ready[0], out_valid[3], out_busy[3]);
            end
        end
        step();
        out_ready[3] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_busy[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_resume_busy: got %b want 1", out_busy[3]);
        end
        @(negedge clk);
        n_checks++;
        if (out_busy[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got %b want 0", out_busy[3]);
        end
        wait_idle("bp");
    endtask

    task automatic test_n0_bubble();
        push_pkt(0, 8'h09);
        push_pkt(0, 8'h09);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_busy[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL n0_grant: got %b want 1", out_busy[2]);
        end
        @(negedge clk);
        n_checks++;
        if (out_busy[2] !== 1'b0 || out_valid[2] !== 1'b0 || in_valid[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL n0_bubble: got busy %b valid %b req %b want 0 0 1",
                     out_busy[2], out_valid[2], in_valid[0]);
        end
        @(negedge clk);
        n_checks++;
        if (out_busy[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL n0_regrant: got %b want 1", out_busy[2]);
        end
        wait_idle("n0");
    endtask

    task automatic test_parallel_clamp();
        push_pkt(3, 8'h10);
        push_pkt(4, 8'h13);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_busy[4:3] !== 2'b11 || out_sel[4*SW +: SW] !== 3'd3 || out_sel[3*SW +: SW] !== 3'd4) begin
            n_fail++;
            $display("FAIL parallel_grant: got busy %b sel4 %0d sel3 %0d want 11 3 4",
                     out_busy[4:3], out_sel[4*SW +: SW], out_sel[3*SW +: SW]);
        end
        wait_idle("parallel");
        step();
        push_pkt(2, 8'h73);
        wait_idle("clamp");
    endtask

    task automatic test_reset_mid();
        step();
        push_pkt(0, 8'h33);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 5'd0 || out_valid !== 5'd0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: got rdy %b valid %b want 0 0", in_ready, out_valid);
        end
        src_q[0].delete();
        exp_q[3].delete();
        step();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_busy !== 5'd0) begin
            n_fail++;
            $display("FAIL rstmid_busy: got %b want 0", out_busy);
        end
        step();
        push_pkt(0, 8'h03);
        push_pkt(4, 8'h03);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_busy[3] !== 1'b1 || out_sel[3*SW +: SW] !== 3'd0) begin
            n_fail++;
            $display("FAIL rstmid_rr: got busy %b sel %0d want 1 0", out_busy[3], out_sel[3*SW +: SW]);
        end
        wait_idle("rstmid");
    endtask

    initial begin
        rst = 1'b1;
        out_ready = '1;
        test_reset();
        step();
        test_single();
        step();
        test_contention();
        step();
        test_backpressure();
        step();
        test_n0_bubble();
        step();
        test_parallel_clamp();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, flit width.
REQ-002 SHALL have parameter CHANNEL_NUMBER, default 5, port count; index 0 local, 1 north, 2 south, 3 east, 4 west.
REQ-003 SHALL have parameters MAX_ROUTERS_X / MAX_ROUTERS_Y, default 4 / 4; X_W = $clog2(MAX_ROUTERS_X), Y_W = $clog2(MAX_ROUTERS_Y).
REQ-004 SHALL have parameters ROUTER_X / ROUTER_Y, default 0 / 0, this router's coordinates.
REQ-005 SHALL have parameter MAXIMUM_PACKAGES_NUMBER, default 5; CNT_W = $clog2(MAXIMUM_PACKAGES_NUMBER).
REQ-006 SHALL use one clock and a synchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port in_valid  in  CHANNEL_NUMBER  per-input flit valid.
REQ-008 SHALL have port in_data  in  CHANNEL_NUMBER*DATA_WIDTH  flattened per-input flit; input i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port in_ready  out  CHANNEL_NUMBER  per-input accept.
REQ-010 SHALL have port out_ready  in  CHANNEL_NUMBER  per-output downstream ready.
REQ-011 SHALL have port out_valid  out  CHANNEL_NUMBER  per-output flit valid.
REQ-012 SHALL have port out_sel  out  CHANNEL_NUMBER*$clog2(CHANNEL_NUMBER)  per-output selected input index, driving the external data mux.
REQ-013 SHALL have port out_busy  out  CHANNEL_NUMBER  output locked to a packet.

Function
REQ-014 Header flit fields: target_x = [X_W-1:0], target_y = [X_W+Y_W-1:X_W], body count N = [X_W+Y_W+CNT_W-1:X_W+Y_W].
REQ-015 A packet is one header plus N body flits; N > MAXIMUM_PACKAGES_NUMBER-1 is clamped to MAXIMUM_PACKAGES_NUMBER-1.
REQ-016 XY route, combinational, per input header: tx>ROUTER_X -> 3; tx<ROUTER_X -> 4; else ty>ROUTER_Y -> 2; ty<ROUTER_Y -> 1; else 0.
REQ-017 An input whose in_valid is high and which is not bound to an output requests exactly its routed output.
REQ-018 Per-output FSM, states IDLE and BUSY.
REQ-019 IDLE: out_busy=0, out_valid=0; if any requests exist, the output grants one round-robin, searching from rr_ptr+1 modulo CHANNEL_NUMBER, loads out_sel and rr_ptr with the winner, binds that input, and moves to BUSY next cycle.
REQ-020 Grant latency: the header becomes visible on out_valid exactly 1 cycle after the request first appears in IDLE.
REQ-021 BUSY: out_valid[o] = in_valid[out_sel[o]]; in_ready[out_sel[o]] = out_ready[o]; a transfer is valid&ready.
REQ-022 Header transfer SHALL load flit counter with N; each body transfer decrements it.
REQ-023 Transfer with counter 0 (header with N=0, or last body flit) SHALL release: unbind input, next state IDLE; no re-arbitration in the release cycle (one bubble).
REQ-024 in_ready[i]=0 for any unbound input, or any input bound to an output in IDLE.
REQ-025 Simultaneous requests to different outputs SHALL be granted in the same cycle, independently.
REQ-026 Backpressure (out_ready=0) SHALL hold the state, counter and out_sel unchanged; in_valid deassertion mid-packet SHALL hold BUSY with no transfer.
REQ-027 An input SHALL be bound to at most one output at a time.

Reset
REQ-028 With rst high at a clock edge, all FSMs SHALL be IDLE, counters 0, rr_ptr = CHANNEL_NUMBER-1 (first search starts at input 0), out_sel 0, and all bindings cleared.
REQ-029 During and directly after reset: out_valid=0, out_busy=0, in_ready=0.
REQ-030 Reset mid-packet SHALL abandon the packet; no flit is accepted in the reset cycle.

Verification (ROUTER_X=1, ROUTER_Y=1, defaults; header bits x[1:0], y[3:2], N[6:4])
REQ-031 Single packet: input 0 header 0x23 (x=3, y=0, N=2), out_ready=1 -> out_busy[3]=1 and out_sel[3]=0 next cycle; 3 transfers on output 3; then IDLE.
REQ-032 Contention: inputs 1 and 2 both route to 0 (header 0x05) simultaneously after reset -> input 1 is served first, input 2 second; with both persistently requesting, grants alternate.
REQ-033 Backpressure: out_ready[3]=0 for 4 cycles mid-body -> in_ready=0, counter unchanged; resume completes with exactly N+1 transfers.
REQ-034 N=0 header 0x09 (to output 2) -> single transfer, IDLE next cycle, bubble of 1 cycle before the next grant.
REQ-035 Parallel: input 3 -> output 4 and input 4 -> output 3 at once -> both granted in the same cycle, no interference.
REQ-036 Reset asserted mid-packet -> out_busy=0 next cycle; the next header re-arbitrates from input 0.
